// File: rtl/fa_cache_control.sv
// fa_cache_control: tag/valid/dirty/true-LRU controller for an 8-way fully-associative 128-bit line array.
// Latency: hit responds in the request cycle; clean miss = fill + 2 cycles; dirty miss = writeback + fill + 2.
// Backpressure: CPU request is a level held until cpu_resp; pmem_read/pmem_write are levels held until pmem_resp.
// Ports: cpu_read/cpu_write/cpu_tag in, cpu_resp/hit_way out (CPU side); array_write/array_index/
//        array_sel_mem/evict_way drive the line array; pmem_read/pmem_write/pmem_tag/pmem_resp is the memory side.
// CPU-facing and array-facing outputs are decoded from the registered state so a hit completes in its request cycle.
module fa_cache_control #(
  parameter int WAYS  = 8,
  parameter int TAG_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_read,
  input  logic             cpu_write,
  input  logic [TAG_W-1:0] cpu_tag,
  output logic             cpu_resp,
  output logic [2:0]       hit_way,
  output logic             array_write,
  output logic [2:0]       array_index,
  output logic             array_sel_mem,
  output logic [2:0]       evict_way,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic [TAG_W-1:0] pmem_tag,
  input  logic             pmem_resp
);

  typedef enum logic [1:0] {S_COMPARE, S_WRITEBACK, S_FILL} state_t;

  state_t           state_q, state_d;
  logic [TAG_W-1:0] tag_q [WAYS];
  logic [TAG_W-1:0] tag_d [WAYS];
  logic [WAYS-1:0]  valid_q, valid_d;
  logic [WAYS-1:0]  dirty_q, dirty_d;
  logic [2:0]       age_q [WAYS];
  logic [2:0]       age_d [WAYS];
  logic [2:0]       victim_q, victim_d;
  logic [TAG_W-1:0] miss_tag_q, miss_tag_d;

  logic             hit;
  logic [2:0]       hit_idx;
  logic [2:0]       victim;

  // Tag match and victim choice. Valid tags are unique, so at most one way matches.
  // Victim: lowest-index invalid way wins over the LRU (age 7) way.
  always_comb begin : lookup
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (valid_q[i] && (tag_q[i] == cpu_tag)) begin
        hit     = 1'b1;
        hit_idx = i[2:0];
      end
    end
    victim = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (age_q[i] == 3'd7) victim = i[2:0];
    end
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_q[i]) victim = i[2:0];
    end
  end

  always_comb begin : next_state
    state_d       = state_q;
    tag_d         = tag_q;
    valid_d       = valid_q;
    dirty_d       = dirty_q;
    age_d         = age_q;
    victim_d      = victim_q;
    miss_tag_d    = miss_tag_q;
    cpu_resp      = 1'b0;
    hit_way       = '0;
    array_write   = 1'b0;
    array_index   = '0;
    array_sel_mem = 1'b0;
    evict_way     = '0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_tag      = '0;
    case (state_q)
      S_COMPARE: begin
        if (cpu_read || cpu_write) begin
          if (hit) begin
            cpu_resp = 1'b1;
            hit_way  = hit_idx;
            // True-LRU touch: everything younger than the hit way ages by one.
            for (int i = 0; i < WAYS; i++) begin
              if (age_q[i] < age_q[hit_idx]) age_d[i] = age_q[i] + 3'd1;
            end
            age_d[hit_idx] = '0;
            // A simultaneous read+write is handled as a write.
            if (cpu_write) begin
              array_write      = 1'b1;
              array_index      = hit_idx;
              dirty_d[hit_idx] = 1'b1;
            end
          end else begin
            victim_d   = victim;
            miss_tag_d = cpu_tag;
            state_d    = (valid_q[victim] && dirty_q[victim]) ? S_WRITEBACK : S_FILL;
          end
        end
      end
      S_WRITEBACK: begin
        pmem_write = 1'b1;
        pmem_tag   = tag_q[victim_q];
        evict_way  = victim_q;
        if (pmem_resp) state_d = S_FILL;
      end
      S_FILL: begin
        pmem_read = 1'b1;
        pmem_tag  = miss_tag_q;
        evict_way = victim_q;
        if (pmem_resp) begin
          array_write       = 1'b1;
          array_index       = victim_q;
          array_sel_mem     = 1'b1;
          tag_d[victim_q]   = miss_tag_q;
          valid_d[victim_q] = 1'b1;
          dirty_d[victim_q] = 1'b0;
          // No LRU touch here: the held request hits next cycle and touches then.
          state_d           = S_COMPARE;
        end
      end
      default: state_d = S_COMPARE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_COMPARE;
      valid_q    <= '0;
      dirty_q    <= '0;
      victim_q   <= '0;
      miss_tag_q <= '0;
      for (int i = 0; i < WAYS; i++) begin
        tag_q[i] <= '0;
        age_q[i] <= i[2:0];
      end
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      age_q      <= age_d;
      victim_q   <= victim_d;
      miss_tag_q <= miss_tag_d;
    end
  end

endmodule

// File: tb/tb_fa_cache_control.sv
// tb_fa_cache_control: directed scenarios for fa_cache_control with a queue-based scoreboard.
// Latency: pmem model answers each request after two cycles of it being raised.
// Backpressure: the CPU request is held until cpu_resp (or dropped on purpose).
module tb_fa_cache_control;

  localparam int TW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_read = 1'b0;
  logic          cpu_write = 1'b0;
  logic [TW-1:0] cpu_tag = '0;
  logic          cpu_resp;
  logic [2:0]    hit_way;
  logic          array_write;
  logic [2:0]    array_index;
  logic          array_sel_mem;
  logic [2:0]    evict_way;
  logic          pmem_read;
  logic          pmem_write;
  logic [TW-1:0] pmem_tag;
  logic          pmem_resp;
  logic          resp_r = 1'b0;
  logic          force_resp = 1'b0;
  logic          resp_en = 1'b1;
  int            rsp_cnt = 0;
  int            n_vec = 0;
  int            n_bad = 0;
  logic          pr_prev = 1'b0;
  logic          pw_prev = 1'b0;

  assign pmem_resp = resp_r | force_resp;

  always #5 clk = ~clk;

  fa_cache_control #(.WAYS(8), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_tag(cpu_tag),
    .cpu_resp(cpu_resp), .hit_way(hit_way),
    .array_write(array_write), .array_index(array_index), .array_sel_mem(array_sel_mem),
    .evict_way(evict_way),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_tag(pmem_tag), .pmem_resp(pmem_resp)
  );

  typedef struct packed {
    logic          resp;
    logic [2:0]    hway;
    logic          aw;
    logic [2:0]    aidx;
    logic          sel;
    logic          pr;
    logic          pw;
    logic [TW-1:0] ptag;
    logic [2:0]    ev;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];

  function automatic obs_t obs_now();
    obs_t o;
    o.resp = cpu_resp;     o.hway = hit_way;
    o.aw   = array_write;  o.aidx = array_index; o.sel = array_sel_mem;
    o.pr   = pmem_read;    o.pw   = pmem_write;  o.ptag = pmem_tag; o.ev = evict_way;
    return o;
  endfunction

  function automatic obs_t e_hit(input logic [2:0] w, input logic wr);
    obs_t o = '0;
    o.resp = 1'b1; o.hway = w; o.aw = wr; o.aidx = wr ? w : 3'd0;
    return o;
  endfunction

  function automatic obs_t e_wb(input logic [TW-1:0] t, input logic [2:0] v);
    obs_t o = '0;
    o.pw = 1'b1; o.ptag = t; o.ev = v;
    return o;
  endfunction

  function automatic obs_t e_fs(input logic [TW-1:0] t, input logic [2:0] v);
    obs_t o = '0;
    o.pr = 1'b1; o.ptag = t; o.ev = v;
    return o;
  endfunction

  function automatic obs_t e_fd(input logic [TW-1:0] t, input logic [2:0] v);
    obs_t o = '0;
    o.pr = 1'b1; o.ptag = t; o.ev = v; o.aw = 1'b1; o.aidx = v; o.sel = 1'b1;
    return o;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input obs_t o, input string nm);
    exp_q.push_back(o);
    name_q.push_back(nm);
  endtask

  // Monitor: an event is a cpu_resp, an array write, or the rising edge of a pmem request.
  initial begin
    obs_t cur;
    obs_t e;
    string nm;
    forever begin
      @(negedge clk);
      cur = obs_now();
      if (rst_n && (cpu_resp || array_write || (pmem_read && !pr_prev) || (pmem_write && !pw_prev))) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_event: got %h expected none", cur);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          check(nm, 32'(cur), 32'(e));
        end
      end
      if (rst_n && pmem_read && pmem_write) check("pmem_exclusive", 32'(1), 32'(0));
      pr_prev = pmem_read;
      pw_prev = pmem_write;
    end
  end

  // pmem model: answers a held request on its second cycle with a one-cycle pulse.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!rst_n || !resp_en) begin
        resp_r  = 1'b0;
        rsp_cnt = 0;
      end else if (resp_r) begin
        resp_r  = 1'b0;
        rsp_cnt = 0;
      end else if (pmem_read || pmem_write) begin
        rsp_cnt++;
        if (rsp_cnt >= 2) resp_r = 1'b1;
      end else begin
        rsp_cnt = 0;
      end
    end
  end

  // Hold a request until cpu_resp; check the number of wait cycles.
  task automatic access(input logic [TW-1:0] t, input logic rd, input logic wr,
                        input int exp_lat, input string nm);
    int waits = 0;
    bit got = 0;
    @(posedge clk); #1;
    cpu_tag = t; cpu_read = rd; cpu_write = wr;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (cpu_resp) got = 1;
      else waits++;
    end
    check({nm, "_lat"}, got ? waits : -1, exp_lat);
    @(posedge clk); #1;
    cpu_read = 1'b0; cpu_write = 1'b0;
  endtask

  task automatic wait_pmem_read(input string nm);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (pmem_read) seen = 1;
    end
    check(nm, 32'(seen), 32'(1));
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  initial begin
    int ways3[7];
    ways3 = '{0, 1, 3, 4, 5, 6, 7};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(obs_now()), 32'(0));
    rst_n = 1'b1;

    // Cold read: fill way 0, then hit way 0
    push(e_fs(12'h00A, 3'd0), "t1_fill_req");
    push(e_fd(12'h00A, 3'd0), "t1_fill_wr");
    push(e_hit(3'd0, 1'b0), "t1_hit");
    access(12'h00A, 1'b1, 1'b0, 3, "t1");

    // Second miss picks lowest invalid way 1, no writeback
    push(e_fs(12'h00B, 3'd1), "t4_fill_req");
    push(e_fd(12'h00B, 3'd1), "t4_fill_wr");
    push(e_hit(3'd1, 1'b0), "t4_hit");
    access(12'h00B, 1'b1, 1'b0, 3, "t4");

    // read+write together on a hit behaves as a write
    push(e_hit(3'd0, 1'b1), "t6_rw_hit");
    access(12'h00A, 1'b1, 1'b1, 0, "t6");

    // Reset in the middle of a fill
    resp_en = 1'b0;
    push(e_fs(12'h00C, 3'd2), "t5_fill_req");
    @(posedge clk); #1;
    cpu_tag = 12'h00C; cpu_read = 1'b1;
    wait_pmem_read("t5_pmem_read_up");
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("t5_pmem_drop", 32'({pmem_read, pmem_write}), 32'(0));
    cpu_read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    resp_en = 1'b1;
    // Previously resident tag must miss after reset
    push(e_fs(12'h00A, 3'd0), "t5_remiss_req");
    push(e_fd(12'h00A, 3'd0), "t5_remiss_wr");
    push(e_hit(3'd0, 1'b0), "t5_remiss_hit");
    access(12'h00A, 1'b1, 1'b0, 3, "t5_remiss");

    // Fill all eight ways with tags 1..8
    reset_pulse();
    for (int k = 1; k <= 8; k++) begin
      push(e_fs(TW'(k), 3'(k - 1)), $sformatf("t2_fill_req_%0d", k));
      push(e_fd(TW'(k), 3'(k - 1)), $sformatf("t2_fill_wr_%0d", k));
      push(e_hit(3'(k - 1), 1'b0), $sformatf("t2_hit_%0d", k));
      access(TW'(k), 1'b1, 1'b0, 3, $sformatf("t2_fill_%0d", k));
    end
    push(e_hit(3'd2, 1'b1), "t2_write_hit");
    access(12'h003, 1'b0, 1'b1, 0, "t2_write");

    // Touch all but way 2, leaving way 2 (dirty) as LRU
    for (int j = 0; j < 7; j++) begin
      push(e_hit(3'(ways3[j]), 1'b0), $sformatf("t3_touch_%0d", ways3[j]));
      access(TW'(ways3[j] + 1), 1'b1, 1'b0, 0, $sformatf("t3_touch_%0d", ways3[j]));
    end
    push(e_wb(12'h003, 3'd2), "t3_wb_req");
    push(e_fs(12'h100, 3'd2), "t3_fill_req");
    push(e_fd(12'h100, 3'd2), "t3_fill_wr");
    push(e_hit(3'd2, 1'b0), "t3_hit");
    access(12'h100, 1'b1, 1'b0, 6, "t3_dirty_miss");

    // Next LRU is way 0 (clean): plain fill
    push(e_fs(12'h003, 3'd0), "lru0_fill_req");
    push(e_fd(12'h003, 3'd0), "lru0_fill_wr");
    push(e_hit(3'd0, 1'b0), "lru0_hit");
    access(12'h003, 1'b1, 1'b0, 3, "lru0_miss");

    // Stray pmem_resp while idle must be ignored
    @(posedge clk); #1; force_resp = 1'b1;
    @(posedge clk); #1; force_resp = 1'b0;
    push(e_hit(3'd3, 1'b0), "stray_then_hit");
    access(12'h004, 1'b1, 1'b0, 0, "stray_hit");

    // Request dropped mid-miss: fill still lands in LRU way 1, no cpu_resp
    push(e_fs(12'h200, 3'd1), "drop_fill_req");
    push(e_fd(12'h200, 3'd1), "drop_fill_wr");
    @(posedge clk); #1;
    cpu_tag = 12'h200; cpu_read = 1'b1;
    wait_pmem_read("drop_pmem_read_up");
    @(posedge clk); #1;
    cpu_read = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("idle_outputs", 32'(obs_now()), 32'(0));
    push(e_hit(3'd1, 1'b0), "drop_then_hit");
    access(12'h200, 1'b1, 1'b0, 0, "drop_hit");

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fa_cache_control.md
Name: fa_cache_control

Overview:
- Controller for the 8-way fully-associative 128-bit line data array.
- Holds per-way tag, valid and dirty state and true-LRU ages.
- Resolves CPU line accesses to hits or misses and drives the array write strobe, way index and datain source.
- Sequences dirty-victim writeback and line fill over a physical-memory req/resp handshake.

Parameters:
WAYS, 8, number of ways; fixed at 8 so the way index is 3 bits.
TAG_W, 12, line tag width: 16-bit address minus the 4-bit line offset.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
cpu_read  in  1  line read request; level, held until cpu_resp.
cpu_write  in  1  line write request; level, held until cpu_resp. Merged line is presented on the array datain by the datapath.
cpu_tag  in  TAG_W  tag of the requested line.
cpu_resp  out  1  one-cycle completion pulse.
hit_way  out  3  way selected for the CPU dataout mux; valid when cpu_resp=1.
array_write  out  1  array write strobe.
array_index  out  3  way written by array_write.
array_sel_mem  out  1  datain source: 1 = pmem line, 0 = CPU-merged line.
evict_way  out  3  way routed to pmem write data.
pmem_read  out  1  line fill request; level.
pmem_write  out  1  line writeback request; level.
pmem_tag  out  TAG_W  tag of the line being transferred.
pmem_resp  in  1  one-cycle pmem completion.

Behaviour:
Reset (asynchronous, rst_n=0):
- State = COMPARE.
- All valid = 0, all dirty = 0, tags = 0.
- age[w] = w, so way 7 is LRU.
- All outputs 0.

Hit detection:
- hit = any way with valid=1 and tag==cpu_tag, evaluated combinationally in COMPARE.
- Tags are unique among valid ways by construction.

State COMPARE:
- No request: all outputs 0.
- Read hit, same cycle:
  - cpu_resp=1, hit_way=hit way.
  - LRU touch of the hit way.
- Write hit, same cycle:
  - Everything a read hit does.
  - array_write=1, array_index=hit way, array_sel_mem=0.
  - dirty[hit way] set at the edge.
- Both cpu_read and cpu_write high: treated as a write.
- Miss:
  - victim = lowest-index invalid way; if all ways are valid, the way with age 7.
  - victim registered into evict_way.
  - Next state is WRITEBACK if the victim is valid and dirty, else FILL.
  - cpu_resp=0.

State WRITEBACK:
- pmem_write=1, pmem_tag=tag[victim], evict_way=victim.
- Held until pmem_resp, then go to FILL.

State FILL:
- pmem_read=1, pmem_tag=cpu_tag latched at miss time.
- On pmem_resp, same cycle:
  - array_write=1, array_index=victim, array_sel_mem=1.
- At that edge:
  - tag[victim] = latched tag, valid=1, dirty=0.
  - Return to COMPARE.
- The held request then hits one cycle later.

Latency:
- Hit: 0 wait cycles; cpu_resp in the request cycle.
- Clean miss: fill time + 2 cycles.
- Dirty miss: writeback time + fill time + 2 cycles.

LRU:
- Ages form a permutation of 0..7.
- Touch of way w: every way with age < age[w] increments; age[w] becomes 0.
- Fill alone does not touch; the following hit does.

Boundary conditions:
- pmem_resp outside WRITEBACK or FILL is ignored.
- A request dropped mid-miss: the miss still completes and the controller returns to COMPARE with no cpu_resp.
- rst_n asserted mid-WRITEBACK or mid-FILL: pmem_read/pmem_write drop immediately and all lines are invalidated.
- pmem_read and pmem_write are never high together.
- array_write is at most one cycle per event.

Test Plan:
1. After reset, read tag 0x00A → FILL with pmem_tag=0x00A and victim way 0. pmem_resp gives array_write=1, index 0, sel_mem=1. Next cycle cpu_resp=1, hit_way=0.
2. Fill tags 0x001..0x008, then write 0x003 → cpu_resp same cycle, array_write=1, index 2, sel_mem=0, dirty[2]=1.
3. Touch 0x001, 0x002, 0x004..0x008, then miss on 0x100 → victim way 2 (dirty). WRITEBACK with pmem_tag=0x003, then FILL with pmem_tag=0x100 into way 2.
4. After scenario 1, miss on 0x00B → victim way 1 (invalid before LRU). No WRITEBACK.
5. Deassert rst_n while pmem_read=1 in FILL → pmem_read=0 with no clock edge. Next read of the prior tag misses.
6. cpu_read=cpu_write=1 on a hit → write behaviour: array_write=1, dirty set.
